// File: rtl/fc_pkg.sv
// Shared types and helpers for the fc_serializer bridge and its ReLU sub-module.
package fc_pkg;

  typedef enum logic [1:0] {eIDLE, eSEND} ser_state_e;

  localparam int FC_WORD_SIZE = 16;
  typedef logic signed [FC_WORD_SIZE-1:0] fc_word_t;

  // Word sits zero/sign-extended in a 64-bit container; msb selects the real sign bit.
  function automatic logic [63:0] fc_relu(input logic [63:0] word, input logic [5:0] msb);
    if (word[msb]) return '0;
    return word;
  endfunction

endpackage

// File: rtl/fc_serializer_if.sv
// Handshake bundle for fc_serializer: packed vector in (valid/yumi), serial words out (valid/ready).
interface fc_serializer_if #(
  parameter int WORD_SIZE    = 16,
  parameter int LAYER_HEIGHT = 2
);
  logic                                valid_i;
  logic                                yumi_o;
  logic [LAYER_HEIGHT*WORD_SIZE-1:0]   data_i;
  logic                                valid_o;
  logic                                ready_i;
  logic signed [WORD_SIZE-1:0]         data_o;
  logic                                last_o;

  modport slave  (input  valid_i, data_i, ready_i,
                  output yumi_o, valid_o, data_o, last_o);
  modport master (output valid_i, data_i, ready_i,
                  input  yumi_o, valid_o, data_o, last_o);
endinterface

// File: rtl/fc_relu_unit.sv
// Combinational ReLU on one signed word: negative words become zero.
module fc_relu_unit
  import fc_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic signed [WORD_SIZE-1:0] i_word,
  output logic signed [WORD_SIZE-1:0] o_word
);

  assign o_word = WORD_SIZE'(fc_relu(64'(i_word), 6'(WORD_SIZE-1)));

endmodule

// File: rtl/fc_serializer.sv
// Parallel-to-serial bridge between fc layers, LSB word first.
// Optional build macro FC_SERIALIZER_RELU_EN applies ReLU to each outgoing word.
module fc_serializer
  import fc_pkg::*;
#(
  parameter int WORD_SIZE    = 16,
  parameter int LAYER_HEIGHT = 2,
  parameter int COUNT_BITS   = (LAYER_HEIGHT == 1) ? 1 : $clog2(LAYER_HEIGHT)
) (
  input logic            clk_i,
  input logic            reset_i,
  fc_serializer_if.slave bus
);

  localparam int                    BUF_W    = LAYER_HEIGHT * WORD_SIZE;
  localparam logic [COUNT_BITS-1:0] LAST_IDX = COUNT_BITS'(LAYER_HEIGHT - 1);

  typedef logic signed [WORD_SIZE-1:0] word_t;

  ser_state_e            r_ps;
  ser_state_e            w_ns;
  logic [COUNT_BITS-1:0] r_count;
  logic [BUF_W-1:0]      r_buf;
  logic                  w_is_last;
  logic                  w_yumi;
  logic                  w_valid;
  logic                  w_last;
  word_t                 w_word;
  word_t                 w_word_out;

  assign w_is_last = (r_count == LAST_IDX);

  always_ff @(posedge clk_i) begin
    if (reset_i) r_ps <= eIDLE;
    else         r_ps <= w_ns;
  end

  always_comb begin
    w_ns = r_ps;
    case (r_ps)
      eIDLE:   if (bus.valid_i) w_ns = eSEND;
      eSEND:   if (bus.ready_i && w_is_last) w_ns = eIDLE;
      default: w_ns = eIDLE;
    endcase
  end

  // valid_o follows ready_i directly: downstream counts words on valid alone.
  always_comb begin
    w_yumi  = 1'b0;
    w_valid = 1'b0;
    w_last  = 1'b0;
    w_word  = '0;
    if (r_ps == eIDLE) begin
      w_yumi = bus.valid_i;
    end else if (r_ps == eSEND) begin
      w_valid = bus.ready_i;
      w_last  = w_is_last;
      w_word  = r_buf[WORD_SIZE-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= '0;
      r_buf   <= '0;
    end else if (w_yumi) begin
      r_count <= '0;
      r_buf   <= bus.data_i;
    end else if (w_valid) begin
      r_count <= w_is_last ? '0 : r_count + COUNT_BITS'(1);
      r_buf   <= r_buf >> WORD_SIZE;
    end
  end

`ifdef FC_SERIALIZER_RELU_EN
  fc_relu_unit #(.WORD_SIZE(WORD_SIZE)) u_relu (
    .i_word (w_word),
    .o_word (w_word_out)
  );
`else
  assign w_word_out = w_word;
`endif

  assign bus.yumi_o  = w_yumi;
  assign bus.valid_o = w_valid;
  assign bus.data_o  = w_word_out;
  assign bus.last_o  = w_last;

endmodule

// File: tb/tb_fc_serializer.sv
// Directed bench for fc_serializer (4-word build plus a 1-word build) with an expected-word scoreboard.
module tb_fc_serializer;

  typedef struct packed {
    logic [15:0] word;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  localparam logic [63:0] V1 = {16'h0004, 16'h0003, 16'hFFFE, 16'h0001};
  localparam logic [63:0] V2 = {16'h8000, 16'h7FFF, 16'h1234, 16'hABCD};
  localparam logic [63:0] V3 = {16'h000D, 16'h800C, 16'h000B, 16'h000A};

  fc_serializer_if #(.WORD_SIZE(16), .LAYER_HEIGHT(4)) bus ();
  fc_serializer_if #(.WORD_SIZE(16), .LAYER_HEIGHT(1)) bus1 ();

  fc_serializer #(.WORD_SIZE(16), .LAYER_HEIGHT(4)) u_dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  fc_serializer #(.WORD_SIZE(16), .LAYER_HEIGHT(1)) u_dut1 (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus1)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] expw(input logic [15:0] w);
`ifdef FC_SERIALIZER_RELU_EN
    return w[15] ? 16'h0000 : w;
`else
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_vec(input logic [63:0] d);
    for (int k = 0; k < 4; k++) exp_q.push_back('{word: expw(d[k*16 +: 16]), last: (k == 3)});
  endtask

  // One cycle on the 4-word DUT: drive at negedge, check combinational outputs 1 time unit later.
  task automatic cyc(input logic r, input logic v, input logic [63:0] d, input logic rdy,
                     input logic ey, input logic ev, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.valid_i = v;
    bus.data_i  = d;
    bus.ready_i = rdy;
    #1;
    chk({tag, "_yumi"}, 16'(bus.yumi_o), 16'(ey));
    chk({tag, "_valid"}, 16'(bus.valid_o), 16'(ev));
    if (bus.valid_o === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, bus.data_o, e.word);
      chk({tag, "_last"}, 16'(bus.last_o), 16'(e.last));
    end else if (!ev) begin
      if (exp_q.size() > 0) begin
        chk({tag, "_hold_data"}, bus.data_o, exp_q[0].word);
        chk({tag, "_hold_last"}, 16'(bus.last_o), 16'(exp_q[0].last));
      end else begin
        chk({tag, "_idle_data"}, bus.data_o, 16'h0000);
        chk({tag, "_idle_last"}, 16'(bus.last_o), 16'h0000);
      end
    end
    if (ey && !r) push_vec(d);
  endtask

  initial begin
    bus.valid_i  = 1'b0;
    bus.data_i   = '0;
    bus.ready_i  = 1'b0;
    bus1.valid_i = 1'b0;
    bus1.data_i  = '0;
    bus1.ready_i = 1'b0;
    repeat (2) @(posedge clk);

    // reset state on both builds
    cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, "reset");
    chk("reset1_valid", 16'(bus1.valid_o), 16'h0000);
    chk("reset1_data", bus1.data_o, 16'h0000);
    chk("reset1_last", 16'(bus1.last_o), 16'h0000);
    chk("reset1_yumi", 16'(bus1.yumi_o), 16'h0000);

    // capture and send
    cyc(1'b0, 1'b1, V1, 1'b1, 1'b1, 1'b0, "t1cap");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, "t1send");
    cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, "t1idle");

    // backpressure on word 2
    cyc(1'b0, 1'b1, V1, 1'b1, 1'b1, 1'b0, "t2cap");
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, "t2send");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, "t2stall");
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, "t2resume");
    cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, "t2idle");

    // busy upstream: valid_i held, second vector one cycle after last_o
    cyc(1'b0, 1'b1, V1, 1'b1, 1'b1, 1'b0, "t3cap");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, V2, 1'b1, 1'b0, 1'b1, "t3busy");
    cyc(1'b0, 1'b1, V2, 1'b1, 1'b1, 1'b0, "t3cap2");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, "t3send2");
    cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, "t3idle");

    // reset after word 1, then a fresh vector from word 0
    cyc(1'b0, 1'b1, V1, 1'b1, 1'b1, 1'b0, "t4cap");
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, "t4send");
    cyc(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, "t4rst");
    exp_q.delete();
    cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, "t4post");
    cyc(1'b0, 1'b1, V3, 1'b1, 1'b1, 1'b0, "t4cap2");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, "t4send2");
    cyc(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, "t4idle");
    chk("queue_empty", 16'(exp_q.size()), 16'h0000);

    // single-word build
    @(negedge clk);
    bus1.valid_i = 1'b1;
    bus1.data_i  = 16'h8001;
    bus1.ready_i = 1'b1;
    #1;
    chk("t6_yumi", 16'(bus1.yumi_o), 16'h0001);
    chk("t6_cap_valid", 16'(bus1.valid_o), 16'h0000);
    @(negedge clk);
    bus1.valid_i = 1'b0;
    #1;
    chk("t6_valid", 16'(bus1.valid_o), 16'h0001);
    chk("t6_last", 16'(bus1.last_o), 16'h0001);
    chk("t6_data", bus1.data_o, expw(16'h8001));
    chk("t6_busy_yumi", 16'(bus1.yumi_o), 16'h0000);
    @(negedge clk);
    #1;
    chk("t6_idle_valid", 16'(bus1.valid_o), 16'h0000);
    chk("t6_idle_last", 16'(bus1.last_o), 16'h0000);
    chk("t6_idle_data", bus1.data_o, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
